// File: rtl/supertile_cfg_pkg.sv
// supertile_cfg_pkg
//   Shared definitions for the supertile configuration loader:
//   loader FSM state encoding and default parameter values.
package supertile_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_COMMIT  = 2'd2
    } cfg_state_t;

    localparam int DEF_NUM_TILES          = 2;
    localparam int DEF_MAX_FRAMES_PER_COL = 20;
    localparam int DEF_FRAME_BITS_PER_ROW = 32;
    localparam int DEF_STROBE_PIPE        = 1;

endpackage

// File: rtl/supertile_cfg_frame_bank.sv
// supertile_cfg_frame_bank
//   Shadow and active configuration storage for one sub-tile.
//   Ports:
//     clk         clock
//     rst         synchronous active-high reset (clears shadow and active)
//     wr_en       per-frame write enable (strobe rising edges)
//     wr_data     frame data for this sub-tile
//     commit_en   copy the whole shadow into active at this clock edge
//     active_bits active configuration, frame f at bits [f*FBR +: FBR]
module supertile_cfg_frame_bank #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [MaxFramesPerCol-1:0]                 wr_en,
    input  logic [FrameBitsPerRow-1:0]                 wr_data,
    input  logic                                       commit_en,
    output logic [MaxFramesPerCol*FrameBitsPerRow-1:0] active_bits
);

    logic [MaxFramesPerCol-1:0][FrameBitsPerRow-1:0] shadow;
    logic [MaxFramesPerCol-1:0][FrameBitsPerRow-1:0] active;

    // Active copies the shadow as it stood before this edge's writes, so a
    // frame written in the commit cycle lands in the next commit instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                if (wr_en[f]) begin
                    shadow[f] <= wr_data;
                end
            end
            if (commit_en) begin
                active <= shadow;
            end
        end
    end

    assign active_bits = active;

endmodule

// File: rtl/supertile_cfg_loader.sv
// supertile_cfg_loader
//   Loads configuration frames for NUM_TILES stacked sub-tiles into shadow
//   storage on FrameStrobe rising edges and copies shadow to active on Commit.
//   Optional readback port guarded by macro SUPERTILE_CFG_READBACK_EN.
//   Ports:
//     UserCLK        clock
//     Reset          synchronous active-high reset
//     FrameData      per-sub-tile frame data, slice t = [t*FBR +: FBR]
//     FrameData_O    chained frame data (registered when STROBE_PIPE=1)
//     FrameStrobe    frame select, written on rising edge only
//     FrameStrobe_O  chained strobe (registered when STROBE_PIPE=1)
//     Commit         copy shadow to active (honoured only while LOADING)
//     ConfigBits     active config, word (t,f) at ((t*MFPC)+f)*FBR
//     FrameCount     distinct frames written since last commit
//     Busy           high in LOADING or COMMIT
//     RbReq/RbTile/RbFrame/RbData/RbValid  registered readback (macro only)
module supertile_cfg_loader
    import supertile_cfg_pkg::*;
#(
    parameter int NUM_TILES       = DEF_NUM_TILES,
    parameter int MaxFramesPerCol = DEF_MAX_FRAMES_PER_COL,
    parameter int FrameBitsPerRow = DEF_FRAME_BITS_PER_ROW,
    parameter int STROBE_PIPE     = DEF_STROBE_PIPE
) (
    input  logic                                                 UserCLK,
    input  logic                                                 Reset,
    input  logic [NUM_TILES*FrameBitsPerRow-1:0]                 FrameData,
    output logic [NUM_TILES*FrameBitsPerRow-1:0]                 FrameData_O,
    input  logic [MaxFramesPerCol-1:0]                           FrameStrobe,
    output logic [MaxFramesPerCol-1:0]                           FrameStrobe_O,
    input  logic                                                 Commit,
    output logic [NUM_TILES*MaxFramesPerCol*FrameBitsPerRow-1:0] ConfigBits,
    output logic [$clog2(MaxFramesPerCol+1)-1:0]                 FrameCount,
    output logic                                                 Busy
`ifdef SUPERTILE_CFG_READBACK_EN
    ,
    input  logic                                                 RbReq,
    input  logic [$clog2(NUM_TILES)-1:0]                         RbTile,
    input  logic [$clog2(MaxFramesPerCol)-1:0]                   RbFrame,
    output logic [FrameBitsPerRow-1:0]                           RbData,
    output logic                                                 RbValid
`endif
);

    localparam int CNT_W = $clog2(MaxFramesPerCol + 1);

    cfg_state_t                 state, state_next;
    logic [MaxFramesPerCol-1:0] strobe_prev;
    logic [MaxFramesPerCol-1:0] strobe_edge;
    logic [MaxFramesPerCol-1:0] written_mask, written_mask_next;
    logic                       commit_en;

    assign strobe_edge = FrameStrobe & ~strobe_prev;

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state        <= ST_IDLE;
            strobe_prev  <= '0;
            written_mask <= '0;
        end else begin
            state        <= state_next;
            strobe_prev  <= FrameStrobe;
            written_mask <= written_mask_next;
        end
    end

    always_comb begin
        state_next        = state;
        commit_en         = 1'b0;
        Busy              = 1'b0;
        written_mask_next = written_mask | strobe_edge;
        case (state)
            ST_IDLE: begin
                if (|strobe_edge) state_next = ST_LOADING;
            end
            ST_LOADING: begin
                Busy = 1'b1;
                if (Commit) state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                Busy              = 1'b1;
                commit_en         = 1'b1;
                // mask restarts with only the edges seen in the commit cycle
                written_mask_next = strobe_edge;
                state_next        = (|strobe_edge) ? ST_LOADING : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        FrameCount = '0;
        for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
            FrameCount = FrameCount + CNT_W'(written_mask[i]);
        end
    end

    genvar t;
    generate
        for (t = 0; t < NUM_TILES; t++) begin : g_bank
            supertile_cfg_frame_bank #(
                .MaxFramesPerCol (MaxFramesPerCol),
                .FrameBitsPerRow (FrameBitsPerRow)
            ) u_bank (
                .clk         (UserCLK),
                .rst         (Reset),
                .wr_en       (strobe_edge),
                .wr_data     (FrameData[t*FrameBitsPerRow +: FrameBitsPerRow]),
                .commit_en   (commit_en),
                .active_bits (ConfigBits[t*MaxFramesPerCol*FrameBitsPerRow +: MaxFramesPerCol*FrameBitsPerRow])
            );
        end
    endgenerate

    generate
        if (STROBE_PIPE != 0) begin : g_pipe
            always_ff @(posedge UserCLK) begin
                if (Reset) begin
                    FrameStrobe_O <= '0;
                    FrameData_O   <= '0;
                end else begin
                    FrameStrobe_O <= FrameStrobe;
                    FrameData_O   <= FrameData;
                end
            end
        end else begin : g_comb
            assign FrameStrobe_O = FrameStrobe;
            assign FrameData_O   = FrameData;
        end
    endgenerate

`ifdef SUPERTILE_CFG_READBACK_EN
    logic [FrameBitsPerRow-1:0] rb_word;

    always_comb begin
        rb_word = '0;
        if (int'(RbTile) < NUM_TILES && int'(RbFrame) < MaxFramesPerCol) begin
            rb_word = ConfigBits[(int'(RbTile)*MaxFramesPerCol + int'(RbFrame))*FrameBitsPerRow +: FrameBitsPerRow];
        end
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            RbValid <= 1'b0;
            RbData  <= '0;
        end else begin
            RbValid <= RbReq;
            if (RbReq) begin
                RbData <= rb_word;
            end
        end
    end
`endif

endmodule
